// File: rtl/xaui_tx_idle_gen.sv
// rtl/xaui_tx_idle_gen.sv - XAUI TX idle generator: ||A||/||K||/||R|| randomisation and ||Q|| insertion
module xaui_tx_idle_gen #(
  parameter int         NCOL      = 1,      // columns per clock, 1 or 2
  parameter logic [6:0] LFSR_SEED = 7'h7F   // must be non-zero
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [32*NCOL-1:0]   txdata_i,
  input  logic [4*NCOL-1:0]    txcharisk_i,
  input  logic                 link_status_event,
  input  logic [31:0]          link_status,
  output logic [32*NCOL-1:0]   txdata_o,
  output logic [4*NCOL-1:0]    txcharisk_o,
  output logic                 a_send,
  output logic                 q_sent
);

  localparam logic [7:0]  SYM_K    = 8'hBC;
  localparam logic [7:0]  SYM_R    = 8'h1C;
  localparam logic [7:0]  SYM_A    = 8'h7C;
  localparam logic [7:0]  SYM_Q    = 8'h9C;
  localparam logic [7:0]  SYM_I    = 8'h07;
  localparam logic [31:0] IDLE_COL = {4{SYM_I}};

  localparam logic IFG_A = 1'b0;
  localparam logic IFG_K = 1'b1;

  typedef enum logic [2:0] {
    SEND_K = 3'd0,
    SEND_A = 3'd1,
    SEND_Q = 3'd2,
    RAND_R = 3'd3,
    RAND_K = 3'd4,
    RAND_A = 3'd5,
    RAND_Q = 3'd6
  } state_e;

  // x^7 + x^6 + 1, shifting towards the MSB; bit 0 is the fresh bit
  function automatic logic [6:0] lfsr_step(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  state_e               state_q, state_d;
  logic                 ifg_q, ifg_d;
  logic                 q_pend_q, q_pend_d;
  logic [4:0]           a_cnt_q, a_cnt_d;
  logic [6:0]           lfsr_q, lfsr_d;
  logic [23:0]          q_payload_q, q_payload_d;

  logic [32*NCOL-1:0]   txdata_q, txdata_d;
  logic [4*NCOL-1:0]    txcharisk_q, txcharisk_d;
  logic                 a_send_q, a_send_d;
  logic                 q_sent_q, q_sent_d;

  // per-column state seen on entry and the data/idle decision, handed to the output logic
  logic [3*NCOL-1:0]    col_st;
  logic [NCOL-1:0]      col_data;

  // the low byte of the Q payload is replaced by the Q symbol and never transmitted
  logic                 unused_ls_lsb;
  assign unused_ls_lsb = ^link_status[7:0];

  // state register: control state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RAND_R;
      ifg_q       <= IFG_A;
      q_pend_q    <= 1'b0;
      a_cnt_q     <= 5'd0;
      lfsr_q      <= LFSR_SEED;
      q_payload_q <= 24'd0;
      txdata_q    <= {(4*NCOL){SYM_K}};
      txcharisk_q <= {(4*NCOL){1'b1}};
      a_send_q    <= 1'b0;
      q_sent_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ifg_q       <= ifg_d;
      q_pend_q    <= q_pend_d;
      a_cnt_q     <= a_cnt_d;
      lfsr_q      <= lfsr_d;
      q_payload_q <= q_payload_d;
      txdata_q    <= txdata_d;
      txcharisk_q <= txcharisk_d;
      a_send_q    <= a_send_d;
      q_sent_q    <= q_sent_d;
    end
  end

  // next-state: walk the columns in order, each one consuming the previous column's state
  always_comb begin : col_chain
    state_e     st;
    state_e     nxt;
    logic       ifg;
    logic       qp;
    logic [4:0] acnt;
    logic [6:0] lf;
    logic       is_data;
    logic       code_sel;
    logic       emit_a;
    logic       emit_q;

    st       = state_q;
    nxt      = state_q;
    ifg      = ifg_q;
    qp       = q_pend_q;
    acnt     = a_cnt_q;
    lf       = lfsr_q;
    is_data  = 1'b0;
    code_sel = 1'b0;
    emit_a   = 1'b0;
    emit_q   = 1'b0;
    col_st   = '0;
    col_data = '0;

    for (int c = 0; c < NCOL; c++) begin
      is_data = (txdata_i[32*c +: 32] != IDLE_COL) || (txcharisk_i[4*c +: 4] != 4'b1111);
      col_st[3*c +: 3] = st;
      col_data[c]      = is_data;
      code_sel         = lf[0];
      emit_a           = !is_data && ((st == SEND_A) || (st == RAND_A));
      emit_q           = !is_data && ((st == SEND_Q) || (st == RAND_Q));

      if (is_data) begin
        nxt = ((ifg == IFG_K) || (acnt == 5'd0)) ? SEND_K : SEND_A;
      end else begin
        case (st)
          SEND_K:  nxt = RAND_R;
          SEND_A:  nxt = qp ? SEND_Q : RAND_R;
          SEND_Q:  nxt = RAND_R;
          RAND_R,
          RAND_K:  nxt = (acnt == 5'd0) ? RAND_A : (code_sel ? RAND_R : RAND_K);
          RAND_A:  nxt = qp ? RAND_Q : (code_sel ? RAND_R : RAND_K);
          RAND_Q:  nxt = code_sel ? RAND_R : RAND_K;
          default: nxt = RAND_R;
        endcase
      end

      // the post-terminate K/A choice alternates between packets
      if (st == SEND_K) begin
        ifg = IFG_A;
      end else if (st == SEND_A) begin
        ifg = IFG_K;
      end

      // every ||A|| restarts the spacing count at 16..31
      if (emit_a) begin
        acnt = {1'b1, lf[4:1]};
      end else if (acnt != 5'd0) begin
        acnt = acnt - 5'd1;
      end

      if (emit_q) begin
        qp = 1'b0;
      end

      lf = lfsr_step(lf);
      st = nxt;
    end

    state_d  = st;
    ifg_d    = ifg;
    a_cnt_d  = acnt;
    lfsr_d   = lf;
    // a new event wins over a Q being sent this cycle so the fresh status is not lost
    q_pend_d    = link_status_event ? 1'b1 : qp;
    q_payload_d = link_status_event ? link_status[31:8] : q_payload_q;
  end

  // output: build each column from its entry state or pass data through
  always_comb begin : col_out
    logic [31:0] din;
    logic [31:0] dout;
    logic [3:0]  kin;
    logic [3:0]  kout;
    state_e      s;

    txdata_d    = '0;
    txcharisk_d = '0;
    a_send_d    = 1'b0;
    q_sent_d    = 1'b0;
    din         = '0;
    dout        = '0;
    kin         = '0;
    kout        = '0;
    s           = RAND_R;

    for (int c = 0; c < NCOL; c++) begin
      din = txdata_i[32*c +: 32];
      kin = txcharisk_i[4*c +: 4];
      s   = state_e'(col_st[3*c +: 3]);

      if (col_data[c]) begin
        dout = din;
        kout = kin;
        // stray idle characters inside a data column (e.g. after ||T||) become K
        for (int b = 0; b < 4; b++) begin
          if (kin[b] && (din[8*b +: 8] == SYM_I)) begin
            dout[8*b +: 8] = SYM_K;
          end
        end
      end else begin
        kout = 4'b1111;
        case (s)
          SEND_Q, RAND_Q: begin
            dout     = {q_payload_q, SYM_Q};
            kout     = 4'b0001;
            q_sent_d = 1'b1;
          end
          SEND_K, RAND_K: dout = {4{SYM_K}};
          SEND_A, RAND_A: dout = {4{SYM_A}};
          default:        dout = {4{SYM_R}};
        endcase
      end

      txdata_d[32*c +: 32]   = dout;
      txcharisk_d[4*c +: 4]  = kout;
      if (dout == {4{SYM_A}}) begin
        a_send_d = 1'b1;
      end
    end
  end

  assign txdata_o    = txdata_q;
  assign txcharisk_o = txcharisk_q;
  assign a_send      = a_send_q;
  assign q_sent      = q_sent_q;

endmodule
